// File: rtl/fp16_pkg.sv
// Shared fp16 field widths, saturation constants and pipeline stage payloads
// for the fp16 add/sub datapaths.
package fp16_pkg;

  localparam int unsigned FP16_W       = 16;
  localparam int unsigned FP16_EXP_W   = 5;
  localparam int unsigned FP16_MANT_W  = 10;
  localparam int unsigned FP16_GUARD_W = 4;
  localparam int unsigned FP16_SIG_W   = 15;
  localparam int unsigned FP16_SUM_W   = 16;
  localparam int unsigned FP16_EXPI_W  = 6;

  localparam int unsigned             FP16_EXP_MAX_FINITE = 30;
  localparam logic [FP16_MANT_W-1:0]  FP16_SAT_MANT       = 10'h3FF;

  // S1 -> S2: aligned significands plus the zero-operand bypass result
  typedef struct packed {
    logic                   sign;
    logic                   sub;
    logic [FP16_EXPI_W-1:0] exp;
    logic [FP16_SIG_W-1:0]  sig_l;
    logic [FP16_SIG_W-1:0]  sig_s;
    logic                   bypass;
    logic [FP16_W-1:0]      bypass_val;
  } fp16_s1_t;

  // S2 -> S3: raw sum awaiting normalization
  typedef struct packed {
    logic                   sign;
    logic [FP16_EXPI_W-1:0] exp;
    logic [FP16_SUM_W-1:0]  sum;
    logic                   bypass;
    logic [FP16_W-1:0]      bypass_val;
  } fp16_s2_t;

  function automatic logic fp16_is_zero(input logic [FP16_W-1:0] x);
    return (x[FP16_W-2:0] == '0);
  endfunction

endpackage

// File: rtl/fp16_sub_normalize.sv
// Leading-one normalizer: carry right-shift or left-shift to bit 14.
// Returned exponent is clamped to 0 when the true exponent is <= 0.
module fp16_sub_normalize
  import fp16_pkg::*;
(
  input  logic [FP16_SUM_W-1:0]  sum_i,
  input  logic [FP16_EXPI_W-1:0] exp_i,
  output logic [FP16_SIG_W-1:0]  sig_o,
  output logic [FP16_EXPI_W-1:0] exp_o
);

  localparam int unsigned EXPX_W = FP16_EXPI_W + 1;

  logic              found;
  logic [3:0]        shamt;
  logic [EXPX_W-1:0] exp_x;

  // Highest set bit among 14..4; bits below the guard field never count
  always_comb begin
    found = 1'b0;
    shamt = '0;
    for (int i = int'(FP16_GUARD_W); i < int'(FP16_SIG_W); i++) begin
      if (sum_i[i]) begin
        found = 1'b1;
        shamt = 4'(int'(FP16_SIG_W) - 1 - i);
      end
    end
  end

  // Extra exponent bit keeps 32 (overflow) apart from negatives (underflow)
  always_comb begin
    sig_o = '0;
    exp_x = {1'b0, exp_i};
    if (sum_i[FP16_SUM_W-1]) begin
      sig_o = sum_i[FP16_SUM_W-1:1];
      exp_x = {1'b0, exp_i} + 7'd1;
    end else if (found) begin
      sig_o = sum_i[FP16_SIG_W-1:0] << shamt;
      exp_x = {1'b0, exp_i} - {3'b000, shamt};
    end
    exp_o = (exp_x[EXPX_W-1] || (exp_x == '0)) ? '0 : exp_x[FP16_EXPI_W-1:0];
  end

endmodule

// File: rtl/fp16_sub_pipe.sv
// Three-stage fp16 subtractor (a - b) with valid/ready flow control.
// Define FP16_SUB_FLAGS_EN to add the ovf_flag / unf_flag outputs.
module fp16_sub_pipe
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP16_W-1:0] operand_a,
  input  logic [FP16_W-1:0] operand_b,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef FP16_SUB_FLAGS_EN
  output logic              ovf_flag,
  output logic              unf_flag,
`endif
  output logic [FP16_W-1:0] diff
);

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic s2_load, s3_load, accept;

  fp16_s1_t s1_q, s1_d;
  fp16_s2_t s2_q, s2_d;
  logic [FP16_W-1:0] diff_q, diff_d;
`ifdef FP16_SUB_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
`endif

  logic [FP16_W-1:0]      b_eff;
  logic [FP16_EXP_W-1:0]  exp_a, exp_b, exp_dist;
  logic [FP16_MANT_W-1:0] mant_a, mant_b;
  logic [FP16_SIG_W-1:0]  sig_a, sig_b, sig_small, sig_aligned;
  logic                   a_big, a_zero, b_zero;

  logic [FP16_SIG_W-1:0]  sig_n;
  logic [FP16_EXPI_W-1:0] exp_n;

  // Stage handshake: each stage loads when empty or when its successor drains
  always_comb begin
    s3_load  = !v3_q || out_ready;
    s2_load  = !v2_q || s3_load;
    in_ready = !v1_q || s2_load;
    accept   = in_valid && in_ready;
    v1_d     = in_ready ? in_valid : v1_q;
    v2_d     = s2_load  ? v1_q     : v2_q;
    v3_d     = s3_load  ? v2_q     : v3_q;
  end

  // S1: unpack, pick the larger magnitude, align the smaller significand
  always_comb begin
    b_eff       = {~operand_b[FP16_W-1], operand_b[FP16_W-2:0]};
    exp_a       = operand_a[FP16_MANT_W +: FP16_EXP_W];
    exp_b       = b_eff[FP16_MANT_W +: FP16_EXP_W];
    mant_a      = operand_a[FP16_MANT_W-1:0];
    mant_b      = b_eff[FP16_MANT_W-1:0];
    a_zero      = fp16_is_zero(operand_a);
    b_zero      = fp16_is_zero(b_eff);
    sig_a       = {1'b1, mant_a, {FP16_GUARD_W{1'b0}}};
    sig_b       = {1'b1, mant_b, {FP16_GUARD_W{1'b0}}};
    a_big       = (exp_a > exp_b) || ((exp_a == exp_b) && (mant_a >= mant_b));
    exp_dist    = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
    sig_small   = a_big ? sig_b : sig_a;
    sig_aligned = (exp_dist >= FP16_EXP_W'(FP16_SIG_W)) ? '0 : (sig_small >> exp_dist);

    s1_d = s1_q;
    if (accept) begin
      s1_d.sign       = a_big ? operand_a[FP16_W-1] : b_eff[FP16_W-1];
      s1_d.sub        = operand_a[FP16_W-1] ^ b_eff[FP16_W-1];
      s1_d.exp        = {1'b0, (a_big ? exp_a : exp_b)};
      s1_d.sig_l      = a_big ? sig_a : sig_b;
      s1_d.sig_s      = sig_aligned;
      s1_d.bypass     = a_zero || b_zero;
      s1_d.bypass_val = a_zero ? (b_zero ? '0 : b_eff) : operand_a;
    end
  end

  // S2: magnitude add or subtract; larger-first ordering keeps it non-negative
  always_comb begin
    s2_d = s2_q;
    if (s2_load && v1_q) begin
      s2_d.sign       = s1_q.sign;
      s2_d.exp        = s1_q.exp;
      s2_d.bypass     = s1_q.bypass;
      s2_d.bypass_val = s1_q.bypass_val;
      s2_d.sum        = s1_q.sub ? ({1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s})
                                 : ({1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s});
    end
  end

  fp16_sub_normalize u_norm (
    .sum_i (s2_q.sum),
    .exp_i (s2_q.exp),
    .sig_o (sig_n),
    .exp_o (exp_n)
  );

  // S3: special-case priority and pack; sig_n is all-zero only on cancellation
  always_comb begin
    diff_d = diff_q;
`ifdef FP16_SUB_FLAGS_EN
    ovf_d  = ovf_q;
    unf_d  = unf_q;
`endif
    if (s3_load && v2_q) begin
`ifdef FP16_SUB_FLAGS_EN
      ovf_d = 1'b0;
      unf_d = 1'b0;
`endif
      if (s2_q.bypass) begin
        diff_d = s2_q.bypass_val;
      end else if (exp_n == '0) begin
        diff_d = '0;
`ifdef FP16_SUB_FLAGS_EN
        unf_d  = 1'b1;
`endif
      end else if (exp_n > FP16_EXPI_W'(FP16_EXP_MAX_FINITE)) begin
        diff_d = {s2_q.sign, FP16_EXP_W'(FP16_EXP_MAX_FINITE), FP16_SAT_MANT};
`ifdef FP16_SUB_FLAGS_EN
        ovf_d  = 1'b1;
`endif
      end else if (sig_n == '0) begin
        diff_d = '0;
      end else begin
        diff_d = {s2_q.sign, exp_n[FP16_EXP_W-1:0], sig_n[FP16_GUARD_W +: FP16_MANT_W]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      diff_q <= '0;
`ifdef FP16_SUB_FLAGS_EN
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
`endif
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      diff_q <= diff_d;
`ifdef FP16_SUB_FLAGS_EN
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
`endif
    end
  end

  // Datapath payloads are qualified by the stage valids and need no reset
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  assign out_valid = v3_q;
  assign diff      = diff_q;
`ifdef FP16_SUB_FLAGS_EN
  assign ovf_flag  = ovf_q;
  assign unf_flag  = unf_q;
`endif

endmodule

// File: tb/tb_fp16_sub_pipe.sv
// Bench for fp16_sub_pipe: directed vectors, backpressure, reset flush and
// random traffic against an integer reference. Honours FP16_SUB_FLAGS_EN.
module tb_fp16_sub_pipe;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] operand_a, operand_b, diff;
`ifdef FP16_SUB_FLAGS_EN
  logic        ovf_flag, unf_flag;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [15:0] d; logic o; logic u; } exp_t;
  exp_t        scb[$];
  logic        dir_en, rand_ready, held_vld;
  exp_t        dir_exp;
  logic [15:0] held_diff;

  fp16_sub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FP16_SUB_FLAGS_EN
    .ovf_flag  (ovf_flag),
    .unf_flag  (unf_flag),
`endif
    .diff      (diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: a - b from the arithmetic rules using plain integers
  function automatic void ref_sub(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] d, output logic o, output logic u);
    logic [15:0] bn;
    int ea, eb, va, vb, big, sml, sh, sum, e, sig, p;
    logic s, a_big, cancel;
    bn = b ^ 16'h8000;
    o = 1'b0;
    u = 1'b0;
    if (a[14:0] == 15'd0 && bn[14:0] == 15'd0) d = 16'h0000;
    else if (a[14:0] == 15'd0) d = bn;
    else if (bn[14:0] == 15'd0) d = a;
    else begin
      ea = int'(a[14:10]);
      eb = int'(bn[14:10]);
      va = (1024 + int'(a[9:0])) * 16;
      vb = (1024 + int'(bn[9:0])) * 16;
      a_big = (ea > eb) || (ea == eb && a[9:0] >= bn[9:0]);
      big = a_big ? va : vb;
      sml = a_big ? vb : va;
      sh  = a_big ? ea - eb : eb - ea;
      e   = a_big ? ea : eb;
      s   = a_big ? a[15] : bn[15];
      sml = (sh >= 15) ? 0 : (sml >> sh);
      sum = (a[15] != bn[15]) ? big - sml : big + sml;
      cancel = 1'b0;
      sig = 0;
      if (sum >= 32768) begin
        sig = sum / 2;
        e = e + 1;
      end else begin
        p = -1;
        for (int i = 4; i <= 14; i++) if (((sum >> i) & 1) == 1) p = i;
        if (p < 0) cancel = 1'b1;
        else begin
          sig = sum << (14 - p);
          e = e - (14 - p);
        end
      end
      if (e <= 0) begin d = 16'h0000; u = 1'b1; end
      else if (e > 30) begin d = {s, 5'd30, 10'h3FF}; o = 1'b1; end
      else if (cancel) d = 16'h0000;
      else d = {s, 5'(e), 10'((sig >> 4) & 1023)};
    end
  endfunction

  function automatic logic [15:0] rnd_a();
    logic [15:0] a;
    a = 16'($urandom);
    case ($urandom_range(0, 9))
      0: a = {a[15], 15'd0};
      1: a = {a[15], 5'd0, a[9:0]};
      2: a = {a[15], 5'd30, a[9:0]};
      default: ;
    endcase
    return a;
  endfunction

  function automatic logic [15:0] rnd_b(input logic [15:0] a);
    logic [15:0] b;
    b = 16'($urandom);
    case ($urandom_range(0, 3))
      1: b = {b[15], a[14:10], b[9:0]};
      2: b = {b[15], 5'(a[14:10] + 5'($urandom_range(1, 3))), b[9:0]};
      3: b = ($urandom_range(0, 1) == 0) ? a : (a ^ 16'h8000);
      default: ;
    endcase
    return b;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int   n;
    logic acc;
    n = 0;
    in_valid  = 1'b1;
    operand_a = a;
    operand_b = b;
    #1;
    do begin
      acc = in_ready;
      cyc();
      n++;
    end while (!acc && n < 50);
    chk("send_accept", 16'(acc), 16'd1);
  endtask

  task automatic send_dir(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] d, input logic o, input logic u);
    dir_exp = '{d, o, u};
    dir_en  = 1'b1;
    send(a, b);
    dir_en  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((scb.size() != 0 || out_valid) && n < 300) begin
      cyc();
      n++;
    end
    chk("drain_empty", 16'(scb.size()), 16'd0);
  endtask

  task automatic lat_check(input string tag, input logic [15:0] d);
    chk({tag, "_c1"}, 16'(out_valid), 16'd0);
    cyc();
    chk({tag, "_c2"}, 16'(out_valid), 16'd0);
    cyc();
    chk({tag, "_c3"}, 16'(out_valid), 16'd1);
    chk({tag, "_diff"}, diff, d);
  endtask

  // Output monitor: in-order scoreboard and hold-stability under backpressure
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      scb.delete();
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        chk("hold_valid", 16'(out_valid), 16'd1);
        chk("hold_diff", diff, held_diff);
      end
      held_vld  = out_valid && !out_ready;
      held_diff = diff;
      if (out_valid && out_ready) begin
        if (scb.size() == 0) chk("spurious_out", 16'(out_valid), 16'd0);
        else begin
          e = scb.pop_front();
          chk("diff", diff, e.d);
`ifdef FP16_SUB_FLAGS_EN
          chk("ovf_flag", 16'(ovf_flag), 16'(e.o));
          chk("unf_flag", 16'(unf_flag), 16'(e.u));
`endif
        end
      end
      if (in_valid && in_ready) begin
        if (dir_en) e = dir_exp;
        else ref_sub(operand_a, operand_b, e.d, e.o, e.u);
        scb.push_back(e);
      end
    end
  end

  initial begin
    logic [15:0] bp_a [5];
    logic [15:0] bp_b [5];
    logic [15:0] ta, tb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operand_a = '0; operand_b = '0;
    dir_en = 1'b0; rand_ready = 1'b0; held_vld = 1'b0;
    dir_exp = '{16'h0000, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_diff", diff, 16'h0000);
`ifdef FP16_SUB_FLAGS_EN
    chk("rst_ovf", 16'(ovf_flag), 16'd0);
    chk("rst_unf", 16'(unf_flag), 16'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 16'(in_ready), 16'd1);

    // Latency and directed vectors
    out_ready = 1'b1;
    send_dir(16'h4000, 16'h3C00, 16'h3C00, 1'b0, 1'b0);
    in_valid = 1'b0;
    lat_check("lat", 16'h3C00);
    cyc();
    send_dir(16'h3C00, 16'h3C00, 16'h0000, 1'b0, 1'b0);
    send_dir(16'h3C00, 16'hC000, 16'h4200, 1'b0, 1'b0);
    send_dir(16'h0000, 16'h3C00, 16'hBC00, 1'b0, 1'b0);
    send_dir(16'h3C00, 16'h0000, 16'h3C00, 1'b0, 1'b0);
    send_dir(16'h7BFF, 16'hFBFF, 16'h7BFF, 1'b1, 1'b0);
    send_dir(16'h0401, 16'h0400, 16'h0000, 1'b0, 1'b1);
    drain();

    // Full throughput with out_ready held high
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      operand_a = rnd_a();
      operand_b = rnd_b(operand_a);
      #1;
      chk("tput_ready", 16'(in_ready), 16'd1);
      if (i >= 3) chk("tput_valid", 16'(out_valid), 16'd1);
      cyc();
    end
    drain();

    // Backpressure: out_ready low for six cycles with five operations queued
    bp_a[0] = 16'h4000; bp_b[0] = 16'h3C00;
    bp_a[1] = 16'h4500; bp_b[1] = 16'hC100;
    bp_a[2] = 16'h3C00; bp_b[2] = 16'h3800;
    bp_a[3] = 16'hC200; bp_b[3] = 16'h4400;
    bp_a[4] = 16'h5000; bp_b[4] = 16'h4F00;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      operand_a = bp_a[i];
      operand_b = bp_b[i];
      #1;
      chk("bp_accept", 16'(in_ready), 16'd1);
      cyc();
    end
    operand_a = bp_a[3];
    operand_b = bp_b[3];
    #1;
    chk("bp_stall", 16'(in_ready), 16'd0);
    repeat (3) begin
      cyc();
      chk("bp_stall_hold", 16'(in_ready), 16'd0);
      chk("bp_out_valid", 16'(out_valid), 16'd1);
    end
    out_ready = 1'b1;
    send(bp_a[3], bp_b[3]);
    send(bp_a[4], bp_b[4]);
    drain();

    // Reset with two operations in flight
    send(16'h4800, 16'h3C00);
    send(16'h4400, 16'hBC00);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 16'(out_valid), 16'd0);
    chk("midrst_diff", diff, 16'h0000);
    cyc();
    rst = 1'b0;
    repeat (4) begin
      cyc();
      chk("postrst_idle", 16'(out_valid), 16'd0);
    end
    chk("postrst_in_ready", 16'(in_ready), 16'd1);
    send_dir(16'h4200, 16'h3C00, 16'h4000, 1'b0, 1'b0);
    in_valid = 1'b0;
    lat_check("postrst_lat", 16'h4000);
    drain();

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        cyc();
      end
      ta = rnd_a();
      tb = rnd_b(ta);
      send(ta, tb);
    end
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
